// File: rtl/mult_pipe_tail.sv
// Register chain that carries multiplier results from the last multiply stage to writeback.
// Each stage has a valid bit; the chain supports stall and flush, and tracks occupancy and pending writes.
module mult_pipe_tail #(
    parameter int STAGES = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int CNT_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic              in_overflow,
    input  logic              stall,
    input  logic              flush,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out_regwrite,
    output logic [ADDR_W-1:0] out_dst,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_overflow,
    output logic [CNT_W-1:0]  occupancy,
    input  logic [ADDR_W-1:0] qa_reg,
    input  logic [ADDR_W-1:0] qb_reg,
    output logic              qa_hit,
    output logic              qb_hit,
    output logic [CNT_W-1:0]  qa_eta,
    output logic [CNT_W-1:0]  qb_eta
);

    // Handshake: the producer presents in_valid with its data and keeps both stable
    // until in_ready=1; a transfer happens at a rising edge with in_valid & in_ready & ~flush.
    logic accept;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] regwrite_q, regwrite_d;
    logic [STAGES-1:0] zero_q, zero_d;
    logic [STAGES-1:0] overflow_q, overflow_d;
    logic [ADDR_W-1:0] dst_q [STAGES];
    logic [ADDR_W-1:0] dst_d [STAGES];
    logic [DATA_W-1:0] result_q [STAGES];
    logic [DATA_W-1:0] result_d [STAGES];
    logic [CNT_W-1:0]  occupancy_q, occupancy_d;

    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall & ~flush;

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        dst_d      = dst_q;
        result_d   = result_q;
        if (flush) begin
            // Data fields are left stale; only the valid/regwrite bits matter.
            valid_d    = '0;
            regwrite_d = '0;
        end else if (!stall) begin
            for (int i = STAGES - 1; i > 0; i--) begin
                valid_d[i]    = valid_q[i-1];
                regwrite_d[i] = regwrite_q[i-1];
                zero_d[i]     = zero_q[i-1];
                overflow_d[i] = overflow_q[i-1];
                dst_d[i]      = dst_q[i-1];
                result_d[i]   = result_q[i-1];
            end
            valid_d[0]    = accept;
            regwrite_d[0] = accept & in_regwrite;
            zero_d[0]     = in_zero;
            overflow_d[0] = in_overflow;
            dst_d[0]      = in_dst;
            result_d[0]   = in_result;
        end
    end

    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy_d = occupancy_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= '0;
            regwrite_q  <= '0;
            zero_q      <= '0;
            overflow_q  <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dst_q[i]    <= '0;
                result_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            occupancy_q <= occupancy_d;
            dst_q       <= dst_d;
            result_q    <= result_d;
        end
    end

    assign out_valid    = valid_q[STAGES-1];
    assign out_regwrite = valid_q[STAGES-1] & regwrite_q[STAGES-1];
    assign out_dst      = dst_q[STAGES-1];
    assign out_result   = result_q[STAGES-1];
    assign out_zero     = zero_q[STAGES-1];
    assign out_overflow = overflow_q[STAGES-1];
    assign occupancy    = occupancy_q;

    // Scan oldest to youngest so the youngest matching stage sets the eta.
    always_comb begin
        qa_hit = 1'b0;
        qa_eta = '0;
        qb_hit = 1'b0;
        qb_eta = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (valid_q[i] && regwrite_q[i] && (dst_q[i] == qa_reg) && (qa_reg != '0)) begin
                qa_hit = 1'b1;
                qa_eta = CNT_W'(STAGES - i);
            end
            if (valid_q[i] && regwrite_q[i] && (dst_q[i] == qb_reg) && (qb_reg != '0)) begin
                qb_hit = 1'b1;
                qb_eta = CNT_W'(STAGES - i);
            end
        end
    end

endmodule
